// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, tag type and operand-bus slicing for the fp adder scheduler
package fp_pkg;
   localparam int FP_WIDTH = 27;
   localparam int ADD_LATENCY = 2;
   localparam int MAX_REQ = 8;
   localparam int TAG_ID_W = $clog2(MAX_REQ);
   typedef struct packed {
      logic valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;
   function automatic logic [FP_WIDTH-1:0] fp_slice(input logic [MAX_REQ*FP_WIDTH-1:0] bus, input logic [TAG_ID_W-1:0] idx);
      return bus[idx*FP_WIDTH +: FP_WIDTH];
   endfunction
endpackage

// File: rtl/fp_adder_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N eligible requesters, owns the rotating pointer
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk_pll,
   input  logic                 rst_n,
   input  logic [N-1:0]         eligible,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [$clog2(N)-1:0] ptr
);
   localparam int W = $clog2(N);
   int idx;
   // scan from the far end so the last hit is the first eligible at or after ptr
   always_comb begin
      grant_valid = 1'b0;
      grant_id = '0;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (eligible[W'(idx)]) begin
            grant_valid = 1'b1;
            grant_id = W'(idx);
         end
      end
      grant = grant_valid ? N'(1) << grant_id : '0;
   end
   always_ff @(posedge clk_pll or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (grant_valid) ptr <= (grant_id == W'(N - 1)) ? '0 : grant_id + 1'b1;
endmodule

// File: rtl/fp_adder_scheduler.sv
// fp_adder_scheduler: shares one pipelined adder among NUM_REQ requesters with
// round-robin issue and tag-routed one-entry result buffers
module fp_adder_scheduler
   import fp_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                        clk_pll,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*FP_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*FP_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [FP_WIDTH-1:0]         fpa_in_1,
   output logic [FP_WIDTH-1:0]         fpa_in_2,
   input  logic [FP_WIDTH-1:0]         fpa_out,
   output logic [NUM_REQ-1:0]          res_valid,
   output logic [NUM_REQ*FP_WIDTH-1:0] res_data,
   input  logic [NUM_REQ-1:0]          res_ready,
   output logic                        idle
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] busy, grant, rel;
   logic grant_valid, tags_busy;
   logic [IW-1:0] grant_id, ptr;
   logic [MAX_REQ*FP_WIDTH-1:0] a_ext, b_ext;
   tag_t tag_q [ADD_LATENCY+1];
   assign a_ext = (MAX_REQ*FP_WIDTH)'(req_a);
   assign b_ext = (MAX_REQ*FP_WIDTH)'(req_b);
   assign req_ready = grant;
   assign rel = res_valid & res_ready;
   assign idle = !(|busy) && !tags_busy;
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk_pll(clk_pll),
      .rst_n(rst_n),
      .eligible(req_valid & ~busy),
      .grant(grant),
      .grant_valid(grant_valid),
      .grant_id(grant_id),
      .ptr(ptr)
   );
   always_comb begin
      tags_busy = 1'b0;
      for (int k = 0; k <= ADD_LATENCY; k++) tags_busy = tags_busy | tag_q[k].valid;
   end
   // idle cycles feed zeros so the adder never sees stale operands
   always_ff @(posedge clk_pll or negedge rst_n)
      if (!rst_n) begin
         fpa_in_1 <= '0;
         fpa_in_2 <= '0;
         for (int k = 0; k <= ADD_LATENCY; k++) tag_q[k] <= '0;
      end else begin
         fpa_in_1 <= grant_valid ? fp_slice(a_ext, TAG_ID_W'(grant_id)) : '0;
         fpa_in_2 <= grant_valid ? fp_slice(b_ext, TAG_ID_W'(grant_id)) : '0;
         tag_q[0] <= '{valid: grant_valid, id: TAG_ID_W'(grant_id)};
         for (int k = 1; k <= ADD_LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic wr, busy_q, valid_q;
      logic [FP_WIDTH-1:0] data_q;
      assign wr = tag_q[ADD_LATENCY].valid && tag_q[ADD_LATENCY].id == TAG_ID_W'(i);
      assign busy[i] = busy_q;
      assign res_valid[i] = valid_q;
      assign res_data[i*FP_WIDTH +: FP_WIDTH] = data_q;
      always_ff @(posedge clk_pll or negedge rst_n)
         if (!rst_n) begin
            busy_q <= 1'b0;
            valid_q <= 1'b0;
            data_q <= '0;
         end else begin
            busy_q <= grant[i] | (busy_q & ~rel[i]);
            valid_q <= wr | (valid_q & ~rel[i]);
            if (wr) data_q <= fpa_out;
         end
   end
endmodule

// File: tb/tb_fp_adder_scheduler.sv
// tb_fp_adder_scheduler: scoreboard bench with a 2-stage adder model behind the scheduler
module tb_fp_adder_scheduler;
   import fp_pkg::*;
   localparam int N = 4;
   localparam int W = FP_WIDTH;
   logic clk_pll = 1'b0, rst_n = 1'b0, idle;
   logic [N-1:0] req_valid = '0, res_ready = '1, req_ready, res_valid;
   logic [N*W-1:0] req_a = '0, req_b = '0, res_data;
   logic [W-1:0] fpa_in_1, fpa_in_2, fpa_out, p1, p2;
   int cyc = 0, vectors = 0, miscompares = 0;
   int rel_cnt [N];
   logic [W-1:0] exp_q [N][$];
   int due_q [N][$];

   fp_adder_scheduler #(.NUM_REQ(N)) dut (
      .clk_pll(clk_pll), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .fpa_in_1(fpa_in_1), .fpa_in_2(fpa_in_2), .fpa_out(fpa_out),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .idle(idle)
   );

   always #5 clk_pll = ~clk_pll;
   always @(posedge clk_pll) cyc <= cyc + 1;

   // stand-in adder: any fixed asymmetric function with ADD_LATENCY register stages
   function automatic logic [W-1:0] fpa_model(input logic [W-1:0] a, input logic [W-1:0] b);
      return a + b + {b[W-2:0], 1'b0};
   endfunction
   always @(posedge clk_pll) begin
      p1 <= fpa_model(fpa_in_1, fpa_in_2);
      p2 <= p1;
   end
   assign fpa_out = p2;

   initial begin
      logic [W-1:0] e;
      int d;
      logic [N-1:0] prev;
      prev = '0;
      for (int i = 0; i < N; i++) rel_cnt[i] = 0;
      forever begin
         @(negedge clk_pll);
         if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
               exp_q[i].delete();
               due_q[i].delete();
            end
            prev = '0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  exp_q[i].push_back(fpa_model(req_a[i*W +: W], req_b[i*W +: W]));
                  due_q[i].push_back(cyc + ADD_LATENCY + 2);
               end
               if (res_valid[i] && !prev[i]) begin
                  vectors++;
                  if (exp_q[i].size() == 0) begin
                     miscompares++;
                     $display("FAIL sb_unexpected[%0d] cycle %0d: res_valid rose with nothing outstanding", i, cyc);
                  end else begin
                     e = exp_q[i].pop_front();
                     d = due_q[i].pop_front();
                     if (res_data[i*W +: W] !== e || cyc != d) begin
                        miscompares++;
                        $display("FAIL sb_result[%0d]: got %h at cycle %0d, want %h at cycle %0d", i, res_data[i*W +: W], cyc, e, d);
                     end
                  end
               end
               if (res_valid[i] && res_ready[i]) rel_cnt[i]++;
            end
            prev = res_valid;
         end
      end
   end

   task automatic step();
      @(posedge clk_pll);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 50) begin
         @(negedge clk_pll);
         if (idle === 1'b1) break;
         n++;
      end
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL wait_idle: idle=%b after 50 cycles, want 1", idle);
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      vectors += 4;
      if ({req_ready, res_valid, idle} !== {4'b0, 4'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_flags: ready=%b res_valid=%b idle=%b, want 0000 0000 1", req_ready, res_valid, idle);
      end
      if ({fpa_in_1, fpa_in_2} !== '0) begin
         miscompares++;
         $display("FAIL reset_fpa_in: %h %h, want 0 0", fpa_in_1, fpa_in_2);
      end
      if (res_data !== '0) begin
         miscompares++;
         $display("FAIL reset_res_data: %h, want 0", res_data);
      end
      if (dut.u_arb.ptr !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_ptr: %0d, want 0", dut.u_arb.ptr);
      end
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_single_op();
      logic [W-1:0] a, b;
      a = 27'h1000000;
      b = 27'h0800000;
      req_a[2*W +: W] = a;
      req_b[2*W +: W] = b;
      req_valid = 4'b0100;
      @(negedge clk_pll);
      vectors++;
      if (req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL single_grant: req_ready=%b, want 0100", req_ready);
      end
      step();
      req_valid = '0;
      @(negedge clk_pll);
      vectors++;
      if (fpa_in_1 !== a || fpa_in_2 !== b) begin
         miscompares++;
         $display("FAIL single_issue: in_1=%h in_2=%h, want %h %h", fpa_in_1, fpa_in_2, a, b);
      end
      repeat (2) @(negedge clk_pll);
      vectors++;
      if (res_valid !== 4'b0 || idle !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early: res_valid=%b idle=%b at T+3, want 0000 0", res_valid, idle);
      end
      @(negedge clk_pll);
      vectors++;
      if (res_valid !== 4'b0100 || res_data[2*W +: W] !== 27'h2800000 || idle !== 1'b0) begin
         miscompares++;
         $display("FAIL single_result: res_valid=%b data=%h idle=%b, want 0100 2800000 0", res_valid, res_data[2*W +: W], idle);
      end
      @(negedge clk_pll);
      vectors++;
      if (res_valid !== 4'b0 || idle !== 1'b1) begin
         miscompares++;
         $display("FAIL single_release: res_valid=%b idle=%b, want 0000 1", res_valid, idle);
      end
      step();
   endtask

   task automatic test_no_grant();
      logic [1:0] p;
      p = dut.u_arb.ptr;
      req_valid = '0;
      repeat (3) begin
         @(negedge clk_pll);
         vectors++;
         if ({fpa_in_1, fpa_in_2} !== '0 || req_ready !== 4'b0 || dut.u_arb.ptr !== p) begin
            miscompares++;
            $display("FAIL no_grant: in=%h/%h ready=%b ptr=%0d, want 0/0 0000 %0d", fpa_in_1, fpa_in_2, req_ready, dut.u_arb.ptr, p);
         end
      end
      step();
   endtask

   task automatic test_fairness();
      int exp_id, grants, g;
      int last_rel [N];
      exp_id = int'(dut.u_arb.ptr);
      grants = 0;
      for (int i = 0; i < N; i++) begin
         last_rel[i] = -100;
         req_a[i*W +: W] = W'($urandom);
         req_b[i*W +: W] = W'($urandom);
      end
      res_ready = '1;
      req_valid = '1;
      repeat (25) begin
         @(negedge clk_pll);
         g = -1;
         if (req_ready !== 4'b0) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            grants++;
            vectors++;
            if (!$onehot(req_ready) || g != exp_id || cyc <= last_rel[g]) begin
               miscompares++;
               $display("FAIL fair_order: ready=%b at cycle %0d (last release %0d), want grant to %0d", req_ready, cyc, (g < 0) ? -1 : last_rel[g], exp_id);
            end
            exp_id = (exp_id + 1) % N;
         end
         for (int i = 0; i < N; i++) if (res_valid[i] && res_ready[i]) last_rel[i] = cyc;
         step();
         if (g >= 0) begin
            req_a[g*W +: W] = W'($urandom);
            req_b[g*W +: W] = W'($urandom);
         end
      end
      vectors++;
      if (grants != 20) begin
         miscompares++;
         $display("FAIL fair_count: %0d grants in 25 cycles, want 20", grants);
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_backpressure();
      int n, base;
      logic [W-1:0] held;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = W'($urandom);
         req_b[i*W +: W] = W'($urandom);
      end
      res_ready = 4'b1101;
      req_valid = '1;
      n = 0;
      while (n < 10) begin
         @(negedge clk_pll);
         if (res_valid[1]) break;
         n++;
      end
      vectors++;
      if (n >= 10) begin
         miscompares++;
         $display("FAIL bp_fill: res_valid[1]=%b after 10 cycles, want 1", res_valid[1]);
      end
      held = res_data[W +: W];
      base = rel_cnt[0] + rel_cnt[2] + rel_cnt[3];
      step();
      repeat (20) begin
         @(negedge clk_pll);
         vectors++;
         if (req_ready[1] !== 1'b0 || res_valid[1] !== 1'b1 || res_data[W +: W] !== held) begin
            miscompares++;
            $display("FAIL bp_hold: ready[1]=%b res_valid[1]=%b data=%h, want 0 1 %h", req_ready[1], res_valid[1], res_data[W +: W], held);
         end
         step();
      end
      vectors++;
      if (rel_cnt[0] + rel_cnt[2] + rel_cnt[3] - base < 9) begin
         miscompares++;
         $display("FAIL bp_others: %0d completions on 0/2/3, want at least 9", rel_cnt[0] + rel_cnt[2] + rel_cnt[3] - base);
      end
      req_valid = '0;
      res_ready = '1;
      @(negedge clk_pll);
      vectors++;
      if (res_valid[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release_cycle: res_valid[1]=%b, want 1", res_valid[1]);
      end
      @(negedge clk_pll);
      vectors++;
      if (res_valid[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_released: res_valid[1]=%b, want 0", res_valid[1]);
      end
      step();
      wait_idle();
   endtask

   task automatic test_tag_routing();
      logic [W-1:0] e3, e0;
      req_a[3*W +: W] = 27'h0123456;
      req_b[3*W +: W] = 27'h0000111;
      req_a[0 +: W] = 27'h7000001;
      req_b[0 +: W] = 27'h0222222;
      e3 = fpa_model(27'h0123456, 27'h0000111);
      e0 = fpa_model(27'h7000001, 27'h0222222);
      req_valid = 4'b1000;
      @(negedge clk_pll);
      vectors++;
      if (req_ready !== 4'b1000) begin
         miscompares++;
         $display("FAIL tag_grant3: req_ready=%b, want 1000", req_ready);
      end
      step();
      req_valid = 4'b0001;
      @(negedge clk_pll);
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL tag_grant0: req_ready=%b, want 0001", req_ready);
      end
      step();
      req_valid = '0;
      repeat (3) @(negedge clk_pll);
      vectors++;
      if (res_valid !== 4'b1000 || res_data[3*W +: W] !== e3) begin
         miscompares++;
         $display("FAIL tag_route3: res_valid=%b data3=%h, want 1000 %h", res_valid, res_data[3*W +: W], e3);
      end
      @(negedge clk_pll);
      vectors++;
      if (res_valid !== 4'b0001 || res_data[0 +: W] !== e0) begin
         miscompares++;
         $display("FAIL tag_route0: res_valid=%b data0=%h, want 0001 %h", res_valid, res_data[0 +: W], e0);
      end
      step();
      wait_idle();
   endtask

   task automatic test_reset_midflight();
      req_a[W +: W] = 27'h0abcdef;
      req_b[W +: W] = 27'h0012345;
      req_valid = 4'b0010;
      @(negedge clk_pll);
      vectors++;
      if (req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL rst_grant1: req_ready=%b, want 0010", req_ready);
      end
      step();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({fpa_in_1, fpa_in_2} !== '0 || res_valid !== 4'b0 || res_data !== '0 || idle !== 1'b1 || dut.u_arb.ptr !== 2'd0) begin
         miscompares++;
         $display("FAIL rst_async: in=%h/%h res_valid=%b res_data=%h idle=%b ptr=%0d, want all reset", fpa_in_1, fpa_in_2, res_valid, res_data, idle, dut.u_arb.ptr);
      end
      step();
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk_pll);
         vectors++;
         if (res_valid !== 4'b0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_ghost: res_valid=%b idle=%b at cycle %0d, want 0000 1", res_valid, idle, cyc);
         end
      end
      vectors++;
      if (dut.u_arb.ptr !== 2'd0) begin
         miscompares++;
         $display("FAIL rst_ptr: %0d, want 0", dut.u_arb.ptr);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_no_grant();
      test_fairness();
      test_backpressure();
      test_tag_routing();
      test_reset_midflight();
      for (int i = 0; i < N; i++) begin
         vectors++;
         if (exp_q[i].size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain[%0d]: %0d results outstanding, want 0", i, exp_q[i].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
